// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take strict priority over queued long-latency results,
// with WAW squash of stale LL entries. Optional starvation guard under WB_STARVE_GUARD_EN.
module wb_arbiter #(
  parameter int REG_WIDTH    = 64,
  parameter int LL_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alu_valid,
  input  logic [4:0]                     alu_rd,
  input  logic [REG_WIDTH-1:0]           alu_data,
  input  logic                           ll_valid,
  output logic                           ll_ready,
  input  logic [4:0]                     ll_rd,
  input  logic [REG_WIDTH-1:0]           ll_data,
  output logic                           reg_write,
  output logic [4:0]                     write_addr,
  output logic [REG_WIDTH-1:0]           write_data,
  output logic                           alu_stall,
  output logic [$clog2(LL_DEPTH+1)-1:0]  fifo_count
);

  localparam int PW = $clog2(LL_DEPTH);
  localparam int CW = $clog2(LL_DEPTH+1);

  logic                 r_vld  [LL_DEPTH];
  logic [4:0]           r_rd   [LL_DEPTH];
  logic [REG_WIDTH-1:0] r_data [LL_DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;

  logic w_alu_wr, w_pop, w_push, w_push_vld, w_head_vld;

  assign ll_ready   = (r_count < CW'(LL_DEPTH));
  assign fifo_count = r_count;
  assign w_alu_wr   = alu_valid && (alu_rd != 5'd0);
  assign w_pop      = !alu_valid && (r_count != '0);
  // rd==0 results are accepted (handshake completes) but never stored
  assign w_push     = ll_valid && ll_ready && (ll_rd != 5'd0);
  assign w_push_vld = !(w_alu_wr && (ll_rd == alu_rd));
  assign w_head_vld = r_vld[r_rd_ptr];

  // Control state and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      reg_write  <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      for (int i = 0; i < LL_DEPTH; i++) r_vld[i] <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // An ALU write is younger than everything queued, so matching entries go stale
      for (int i = 0; i < LL_DEPTH; i++) begin
        if (w_push && (r_wr_ptr == PW'(i)))
          r_vld[i] <= w_push_vld;
        else if (w_alu_wr && (r_rd[i] == alu_rd))
          r_vld[i] <= 1'b0;
      end
      reg_write <= w_alu_wr || (w_pop && w_head_vld);
      if (w_alu_wr) begin
        write_addr <= alu_rd;
        write_data <= alu_data;
      end else if (w_pop && w_head_vld) begin
        write_addr <= r_rd[r_rd_ptr];
        write_data <= r_data[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wr_ptr]   <= ll_rd;
      r_data[r_wr_ptr] <= ll_data;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT+1);

  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starve_nxt;
  logic          r_alu_stall;

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop)
      w_starve_nxt = '0;
    else if ((r_count != '0) && (r_starve != SW'(STARVE_LIMIT)))
      w_starve_nxt = r_starve + SW'(1);
  end

  // Starvation guard: stall holds from the limit until the cycle after a pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve    <= '0;
      r_alu_stall <= 1'b0;
    end else begin
      r_starve    <= w_starve_nxt;
      r_alu_stall <= !w_pop && (w_starve_nxt == SW'(STARVE_LIMIT));
    end
  end

  assign alu_stall = r_alu_stall;
`else
  assign alu_stall = (STARVE_LIMIT > 0) & 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model, directed scenarios
// with literal expectations, then randomized traffic compared every cycle.
module tb_wb_arbiter;

  localparam int RW = 64;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [RW-1:0] alu_data;
  logic          ll_valid;
  logic          ll_ready;
  logic [4:0]    ll_rd;
  logic [RW-1:0] ll_data;
  logic          reg_write;
  logic [4:0]    write_addr;
  logic [RW-1:0] write_data;
  logic          alu_stall;
  logic [2:0]    fifo_count;

  wb_arbiter #(.REG_WIDTH(RW), .LL_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data),
    .alu_stall(alu_stall), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit [4:0]    rd;
    bit [RW-1:0] d;
  } ent_t;

  ent_t        q[$];
  bit          exp_rw;
  bit [4:0]    exp_addr;
  bit [RW-1:0] exp_data;
  bit          exp_stall;
  int          m_starve;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_rw = 0; exp_addr = 0; exp_data = 0; exp_stall = 0; m_starve = 0;
  endtask

  // Reference: ALU wins, otherwise the oldest queued result drains; matching rd kills stale entries
  task automatic model_step(input bit av, input bit [4:0] ard, input bit [RW-1:0] ad,
                            input bit lv, input bit [4:0] lrd, input bit [RW-1:0] ld);
    bit   aw;
    bit   acc;
    bit   pop;
    bit   was_busy;
    ent_t e;
    aw = av && (ard != 0);
    acc = lv && (q.size() < DEPTH);
    pop = !av && (q.size() > 0);
    was_busy = (q.size() > 0);
    if (aw) foreach (q[i]) if (q[i].rd == ard) q[i].v = 0;
    exp_rw = 0;
    if (aw) begin
      exp_rw = 1; exp_addr = ard; exp_data = ad;
    end else if (pop) begin
      e = q.pop_front();
      if (e.v) begin
        exp_rw = 1; exp_addr = e.rd; exp_data = e.d;
      end
    end
    if (acc && lrd != 0) begin
      e.v = !(aw && lrd == ard); e.rd = lrd; e.d = ld;
      q.push_back(e);
    end
`ifdef WB_STARVE_GUARD_EN
    if (pop) m_starve = 0;
    else if (was_busy && m_starve < LIMIT) m_starve++;
    exp_stall = !pop && (m_starve == LIMIT);
`else
    exp_stall = was_busy & 1'b0;
`endif
  endtask

  task automatic compare_all();
    chk("reg_write", {63'd0, reg_write}, {63'd0, exp_rw});
    chk("write_addr", {59'd0, write_addr}, {59'd0, exp_addr});
    chk("write_data", write_data, exp_data);
    chk("alu_stall", {63'd0, alu_stall}, {63'd0, exp_stall});
    chk("fifo_count", {61'd0, fifo_count}, 64'(q.size()));
    chk("ll_ready", {63'd0, ll_ready}, {63'd0, (q.size() < DEPTH)});
  endtask

  task automatic drive(input bit av, input bit [4:0] ard, input bit [RW-1:0] ad,
                       input bit lv, input bit [4:0] lrd, input bit [RW-1:0] ld);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ll_valid = lv; ll_rd = lrd; ll_data = ld;
    model_step(av, ard, ad, lv, lrd, ld);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    alu_valid = 0; ll_valid = 0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_count", {61'd0, fifo_count}, 64'd0);
    chk("rst_reg_write", {63'd0, reg_write}, 64'd0);
    chk("rst_ll_ready", {63'd0, ll_ready}, 64'd1);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    model_reset();
    @(negedge clk);
    chk("init_reg_write", {63'd0, reg_write}, 64'd0);
    chk("init_write_addr", {59'd0, write_addr}, 64'd0);
    chk("init_write_data", write_data, 64'd0);
    chk("init_count", {61'd0, fifo_count}, 64'd0);
    chk("init_ll_ready", {63'd0, ll_ready}, 64'd1);
    chk("init_stall", {63'd0, alu_stall}, 64'd0);
    rst = 1'b0;

    // ALU only: one-cycle latency
    drive(1, 5, 'hAA, 0, 0, 0);
    chk("alu_rw", {63'd0, reg_write}, 64'd1);
    chk("alu_addr", {59'd0, write_addr}, 64'd5);
    chk("alu_data", write_data, 64'hAA);

    // LL idle path: FIFO then regfile
    drive(0, 0, 0, 1, 7, 'h55);
    chk("ll_count1", {61'd0, fifo_count}, 64'd1);
    chk("ll_rw_early", {63'd0, reg_write}, 64'd0);
    idle();
    chk("ll_rw", {63'd0, reg_write}, 64'd1);
    chk("ll_addr", {59'd0, write_addr}, 64'd7);
    chk("ll_data", write_data, 64'h55);

    // Full FIFO behind a busy ALU, then in-order drain
    for (int i = 0; i < 4; i++) drive(1, 5'(1 + i), 64'(i), 1, 5'(10 + i), 64'h100 + 64'(i));
    chk("full_count", {61'd0, fifo_count}, 64'd4);
    chk("full_ready", {63'd0, ll_ready}, 64'd0);
    idle();
    chk("drain_ready", {63'd0, ll_ready}, 64'd1);
    chk("drain0_addr", {59'd0, write_addr}, 64'd10);
    for (int i = 1; i < 4; i++) begin
      idle();
      chk("drain_addr", {59'd0, write_addr}, 64'(10 + i));
      chk("drain_data", write_data, 64'h100 + 64'(i));
    end

    // Squash: younger ALU write to rd 3 kills the queued LL write
    drive(0, 0, 0, 1, 3, 'h77);
    drive(1, 3, 'h11, 0, 0, 0);
    chk("sq_alu_data", write_data, 64'h11);
    idle();
    chk("sq_rw", {63'd0, reg_write}, 64'd0);
    chk("sq_keep", write_data, 64'h11);
    chk("sq_count", {61'd0, fifo_count}, 64'd0);

    // rd==0 from either source never writes and never queues
    drive(1, 0, 'hFF, 0, 0, 0);
    chk("rd0_alu_rw", {63'd0, reg_write}, 64'd0);
    drive(0, 0, 0, 1, 0, 'h99);
    chk("rd0_ll_count", {61'd0, fifo_count}, 64'd0);

`ifdef WB_STARVE_GUARD_EN
    drive(0, 0, 0, 1, 9, 'h9);
    for (int i = 0; i < 7; i++) drive(1, 1, 64'(i), 0, 0, 0);
    chk("guard_pre", {63'd0, alu_stall}, 64'd0);
    drive(1, 1, 0, 0, 0, 0);
    chk("guard_on", {63'd0, alu_stall}, 64'd1);
    idle();
    chk("guard_off", {63'd0, alu_stall}, 64'd0);
`endif

    // Reset mid-operation with three entries queued
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 5'(20 + i), 64'(i));
    chk("pre_rst_count", {61'd0, fifo_count}, 64'd3);
    do_reset();
    chk("rst_addr", {59'd0, write_addr}, 64'd0);

    // Randomized traffic, small rd range so squashes are frequent
    for (int n = 0; n < 1500; n++) begin
      if (n == 750) do_reset();
      drive(($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), {$urandom, $urandom},
            ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
